alu_exec_unit: RTL and testbench

Multi-cycle execute unit sitting directly downstream of the ALU operation decoder. It consumes the 4-bit `Operation` code plus two 32-bit operands, computes the result, branch decision and halt flag, and returns them through a valid/ready handshake. Shifts run through an iterative one-bit-per-cycle shifter so the datapath stays small, which makes completion time variable. The execute stage stalls on `in_ready`.

---
 rtl/alu_exec_pkg.sv | 27 ++
 rtl/alu_exec_unit_shifter.sv | 55 +++++
 rtl/alu_exec_unit.sv | 152 +++++++++++++++
 tb/tb_alu_exec_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// Shared operation codes and FSM state type for the ALU execute unit.
package alu_exec_pkg;

  localparam logic [3:0] OP_AND     = 4'b0000;
  localparam logic [3:0] OP_OR      = 4'b0001;
  localparam logic [3:0] OP_ADD     = 4'b0010;
  localparam logic [3:0] OP_XOR     = 4'b0011;
  localparam logic [3:0] OP_SUB     = 4'b0100;
  localparam logic [3:0] OP_SLT     = 4'b0101;
  localparam logic [3:0] OP_HALT    = 4'b0110;
  localparam logic [3:0] OP_ADD_ALT = 4'b0111;
  localparam logic [3:0] OP_BEQ     = 4'b1000;
  localparam logic [3:0] OP_SLL     = 4'b1001;
  localparam logic [3:0] OP_SRL     = 4'b1010;
  localparam logic [3:0] OP_SRA     = 4'b1011;
  localparam logic [3:0] OP_BGE     = 4'b1100;
  localparam logic [3:0] OP_BNE     = 4'b1101;
  localparam logic [3:0] OP_BLT     = 4'b1110;
  localparam logic [3:0] OP_PASSB   = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_exec_state_t;

endpackage

// File: rtl/alu_exec_unit_shifter.sv
// Iterative one-bit-per-cycle shifter; next_value is the word after this cycle's shift,
// done flags the cycle whose shift is the last one.
module alu_iter_shifter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [XLEN-1:0] data,
  input  logic [4:0]      shamt,
  input  logic            shift_left,
  input  logic            arith,
  output logic [XLEN-1:0] next_value,
  output logic            done
);

  logic [XLEN-1:0] work_r;
  logic [4:0]      count_r;
  logic            left_r;
  logic            arith_r;

  // Single-bit shift of the working register in the latched direction.
  always_comb begin
    next_value = work_r;
    if (left_r) begin
      next_value = {work_r[XLEN-2:0], 1'b0};
    end else begin
      next_value = {(arith_r & work_r[XLEN-1]), work_r[XLEN-1:1]};
    end
  end

  assign done = (count_r == 5'd1);

  // Load operands on accept, then shift once per cycle until the counter drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_r  <= {XLEN{1'b0}};
      count_r <= 5'd0;
      left_r  <= 1'b0;
      arith_r <= 1'b0;
    end else if (load) begin
      work_r  <= data;
      count_r <= shamt;
      left_r  <= shift_left;
      arith_r <= arith;
    end else if (count_r != 5'd0) begin
      work_r  <= next_value;
      count_r <= count_r - 5'd1;
    end else begin
      work_r  <= work_r;
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute unit with valid/ready handshakes and registered outputs.
// Define ALU_EXEC_FAST_SHIFT_EN for a single-cycle barrel shifter instead of the iterative one.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      Operation,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            branch_taken,
  output logic            halt,
  output logic            zero
);

  alu_exec_state_t state_r;
  logic [XLEN-1:0] comb_result_s;
  logic            comb_taken_s;
  logic            comb_halt_s;
  logic [4:0]      shamt_s;
  logic            is_shift_s;

  assign shamt_s    = src_b[4:0];
  assign is_shift_s = (Operation == OP_SLL) || (Operation == OP_SRL) || (Operation == OP_SRA);

  // Single-cycle result for every op; shifts here only cover shamt 0 unless fast shift is built.
  always_comb begin
    comb_result_s = {XLEN{1'b0}};
    comb_taken_s  = 1'b0;
    comb_halt_s   = 1'b0;
    case (Operation)
      OP_AND:     comb_result_s = src_a & src_b;
      OP_OR:      comb_result_s = src_a | src_b;
      OP_ADD:     comb_result_s = src_a + src_b;
      OP_ADD_ALT: comb_result_s = src_a + src_b;
      OP_XOR:     comb_result_s = src_a ^ src_b;
      OP_SUB:     comb_result_s = src_a - src_b;
      OP_SLT:     comb_result_s = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_HALT:    comb_halt_s   = 1'b1;
      OP_BEQ:     comb_taken_s  = (src_a == src_b);
      OP_BNE:     comb_taken_s  = (src_a != src_b);
      OP_BGE:     comb_taken_s  = ($signed(src_a) >= $signed(src_b));
      OP_BLT:     comb_taken_s  = ($signed(src_a) < $signed(src_b));
      OP_PASSB:   comb_result_s = src_b;
`ifdef ALU_EXEC_FAST_SHIFT_EN
      OP_SLL:     comb_result_s = src_a << shamt_s;
      OP_SRL:     comb_result_s = src_a >> shamt_s;
      OP_SRA:     comb_result_s = $unsigned($signed(src_a) >>> shamt_s);
`else
      OP_SLL:     comb_result_s = src_a;
      OP_SRL:     comb_result_s = src_a;
      OP_SRA:     comb_result_s = src_a;
`endif
      default:    comb_result_s = {XLEN{1'b0}};
    endcase
    if (comb_taken_s) begin
      comb_result_s = {{(XLEN-1){1'b0}}, 1'b1};
    end else begin
      comb_result_s = comb_result_s;
    end
  end

`ifndef ALU_EXEC_FAST_SHIFT_EN
  logic            sh_load_s;
  logic [XLEN-1:0] sh_next_s;
  logic            sh_done_s;

  assign sh_load_s = (state_r == IDLE) && in_valid && is_shift_s && (shamt_s != 5'd0);

  alu_iter_shifter #(.XLEN(XLEN)) u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (sh_load_s),
    .data       (src_a),
    .shamt      (shamt_s),
    .shift_left (Operation == OP_SLL),
    .arith      (Operation == OP_SRA),
    .next_value (sh_next_s),
    .done       (sh_done_s)
  );
`endif

  // Control FSM; all handshake signals and results are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      result       <= {XLEN{1'b0}};
      branch_taken <= 1'b0;
      halt         <= 1'b0;
      zero         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (!in_valid) begin
            state_r <= IDLE;
`ifndef ALU_EXEC_FAST_SHIFT_EN
          end else if (is_shift_s && (shamt_s != 5'd0)) begin
            state_r  <= SHIFT;
            in_ready <= 1'b0;
`endif
          end else begin
            state_r      <= DONE;
            in_ready     <= 1'b0;
            out_valid    <= 1'b1;
            result       <= comb_result_s;
            branch_taken <= comb_taken_s;
            halt         <= comb_halt_s;
            zero         <= (comb_result_s == {XLEN{1'b0}});
          end
        end
`ifndef ALU_EXEC_FAST_SHIFT_EN
        SHIFT: begin
          if (sh_done_s) begin
            state_r      <= DONE;
            out_valid    <= 1'b1;
            result       <= sh_next_s;
            branch_taken <= 1'b0;
            halt         <= 1'b0;
            zero         <= (sh_next_s == {XLEN{1'b0}});
          end else begin
            state_r <= SHIFT;
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            state_r   <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, reset abort, random ops vs model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  Operation = 4'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        branch_taken;
  logic        halt;
  logic        zero;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .Operation    (Operation),
    .src_a        (src_a),
    .src_b        (src_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .branch_taken (branch_taken),
    .halt         (halt),
    .zero         (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          hold;
    logic [31:0] eres;
    logic        etaken;
    logic        ehalt;
    int          elat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Reference model: straight from the operation table.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic taken, output logic hlt, output int lat);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    int sh;
    sa = a; sb = b; sh = int'(b[4:0]);
    res = 32'd0; taken = 1'b0; hlt = 1'b0; lat = 1;
    case (op)
      4'd0: res = a & b;
      4'd1: res = a | b;
      4'd2, 4'd7: res = a + b;
      4'd3: res = a ^ b;
      4'd4: res = a - b;
      4'd5: res = (sa < sb) ? 32'd1 : 32'd0;
      4'd6: hlt = 1'b1;
      4'd8: taken = (a == b);
      4'd9: res = a << sh;
      4'd10: res = a >> sh;
      4'd11: res = sa >>> sh;
      4'd12: taken = (sa >= sb);
      4'd13: taken = (a != b);
      4'd14: taken = (sa < sb);
      default: res = b;
    endcase
    if (taken) res = 32'd1;
`ifndef ALU_EXEC_FAST_SHIFT_EN
    if (op >= 4'd9 && op <= 4'd11) lat = 1 + sh;
`endif
  endtask

  task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int hold, input logic [31:0] eres,
                        input logic etaken, input logic ehalt, input int elat);
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    if (cyc >= 100) check({nm, "_ready_timeout"}, 32'(in_ready), 32'd1);
    Operation = op; src_a = a; src_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    check({nm, "_latency"}, 32'(cyc), 32'(elat));
    check({nm, "_result"}, result, eres);
    check({nm, "_taken"}, 32'(branch_taken), 32'(etaken));
    check({nm, "_halt"}, 32'(halt), 32'(ehalt));
    check({nm, "_zero"}, 32'(zero), 32'(eres == 32'd0));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({nm, "_hold_result"}, result, eres);
      check({nm, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({nm, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({nm, "_post_valid"}, 32'(out_valid), 32'd0);
    check({nm, "_post_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] mres;
    logic        mtaken;
    logic        mhalt;
    int          mlat;
    logic [3:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0] = '{"add_wrap", 4'b0010, 32'h7FFF_FFFF, 32'h1, 0, 32'h8000_0000, 1'b0, 1'b0, 1};
    vecs[1] = '{"sub_zero", 4'b0100, 32'd5, 32'd5, 0, 32'h0, 1'b0, 1'b0, 1};
    vecs[2] = '{"sra_4", 4'b1011, 32'h8000_0000, 32'd4, 0, 32'hF800_0000, 1'b0, 1'b0, 5};
    vecs[3] = '{"sll_0", 4'b1001, 32'hDEAD_BEEF, 32'd0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1};
    vecs[4] = '{"blt", 4'b1110, 32'hFFFF_FFFF, 32'd1, 0, 32'd1, 1'b1, 1'b0, 1};
    vecs[5] = '{"bge", 4'b1100, 32'hFFFF_FFFF, 32'd1, 0, 32'd0, 1'b0, 1'b0, 1};
    vecs[6] = '{"bne", 4'b1101, 32'd3, 32'd3, 0, 32'd0, 1'b0, 1'b0, 1};
    vecs[7] = '{"xor_bp", 4'b0011, 32'h0000_F0F0, 32'h0000_0FF0, 5, 32'h0000_FF00, 1'b0, 1'b0, 1};
    vecs[8] = '{"halt", 4'b0110, 32'h1234, 32'h5678, 0, 32'd0, 1'b0, 1'b1, 1};
    vecs[9] = '{"passb", 4'b1111, 32'hAAAA_AAAA, 32'h1234_5000, 0, 32'h1234_5000, 1'b0, 1'b0, 1};
`ifdef ALU_EXEC_FAST_SHIFT_EN
    vecs[2].elat = 1;
`endif

    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_taken", 32'(branch_taken), 32'd0);
    check("rst_halt", 32'(halt), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hold,
             vecs[i].eres, vecs[i].etaken, vecs[i].ehalt, vecs[i].elat);
    end

    // Reset mid-shift of SLL by 20 must abort and discard the result.
    Operation = 4'b1001; src_a = 32'd1; src_b = 32'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("abort_busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (25) begin
      @(posedge clk); #1;
      check("abort_no_result", 32'(out_valid), 32'd0);
    end

    // Shamt 31 takes 32 cycles total.
    model(4'b1010, 32'hFFFF_FFFF, 32'd31, mres, mtaken, mhalt, mlat);
    run_op("srl_31", 4'b1010, 32'hFFFF_FFFF, 32'd31, 1, mres, mtaken, mhalt, mlat);

    for (int n = 0; n < 60; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 31)) : $urandom;
      if ($urandom_range(0, 4) == 0) rb = ra;
      model(rop, ra, rb, mres, mtaken, mhalt, mlat);
      run_op($sformatf("rand%0d_op%0d", n, rop), rop, ra, rb, $urandom_range(0, 2),
             mres, mtaken, mhalt, mlat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
